// File: rtl/streaming_histogram_binned_if.sv
// Stream, clear, query and status signals of the binned streaming histogram.
// The producer/reader side takes the master modport; the histogram takes slave.
interface streaming_histogram_binned_if #(
  parameter int LOG2_LANES  = 2,
  parameter int WORD_WIDTH  = 12,
  parameter int BIN_BITS    = 6,
  parameter int COUNT_WIDTH = 32
);
  localparam int LANES      = 2**LOG2_LANES;
  localparam int DATA_WIDTH = WORD_WIDTH * LANES;

  logic                   stream_valid;
  logic                   stream_ready;
  logic [DATA_WIDTH-1:0]  stream_data;
  logic [LANES-1:0]       stream_keep;
  logic                   clear_req;
  logic                   clear_busy;
  logic                   query_valid;
  logic [BIN_BITS-1:0]    query_bin;
  logic                   result_valid;
  logic [COUNT_WIDTH-1:0] result_count;
  logic [COUNT_WIDTH-1:0] total_count;
  logic                   overflow;

  modport master (
    output stream_valid, stream_data, stream_keep, clear_req, query_valid, query_bin,
    input  stream_ready, clear_busy, result_valid, result_count, total_count, overflow
  );

  modport slave (
    input  stream_valid, stream_data, stream_keep, clear_req, query_valid, query_bin,
    output stream_ready, clear_busy, result_valid, result_count, total_count, overflow
  );
endinterface

// File: rtl/streaming_histogram_binned.sv
// Multi-lane streaming histogram. Each kept lane word is binned by its top
// BIN_BITS bits; per-bin and total counters saturate and raise a sticky
// overflow flag. A clear engine drains the pipeline, then zeroes one bin per
// cycle. Bins are read back through a registered, never-stalling query port.
module streaming_histogram_binned #(
  parameter int LOG2_LANES  = 2,
  parameter int WORD_WIDTH  = 12,
  parameter int BIN_BITS    = 6,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  streaming_histogram_binned_if.slave   bus
);
  localparam int LANES = 2**LOG2_LANES;
  localparam int NBINS = 2**BIN_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t                 state, state_nxt;
  logic [BIN_BITS-1:0]    clr_idx;
  logic                   ready_q;
  logic                   accept;

  logic [BIN_BITS-1:0]    bin_p1 [LANES];
  logic [LANES-1:0]       vld_p1;

  logic [COUNT_WIDTH-1:0] cnt     [NBINS];
  logic [COUNT_WIDTH-1:0] cnt_nxt [NBINS];
  logic [LOG2_LANES:0]    n_bin   [NBINS];
  logic [NBINS-1:0]       bin_sat;
  logic [LOG2_LANES:0]    n_total;
  logic [COUNT_WIDTH-1:0] total_q, total_nxt;
  logic                   total_sat;
  logic                   ovf_q;

  logic                   res_vld_q;
  logic [COUNT_WIDTH-1:0] res_cnt_q;

  // Saturating add of a small lane count; MSB of the result flags clipping.
  function automatic logic [COUNT_WIDTH:0] sat_add(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [LOG2_LANES:0]    inc
  );
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + {{(COUNT_WIDTH-LOG2_LANES){1'b0}}, inc};
    if (s[COUNT_WIDTH]) return {1'b1, {COUNT_WIDTH{1'b1}}};
    return s;
  endfunction

  assign accept           = bus.stream_valid & ready_q;
  assign bus.stream_ready = ready_q;
  assign bus.clear_busy   = (state != ST_IDLE);
  assign bus.result_valid = res_vld_q;
  assign bus.result_count = res_cnt_q;
  assign bus.total_count  = total_q;
  assign bus.overflow     = ovf_q;

  // Clear sequencer: state register, clear index and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      if (state == ST_DRAIN)      clr_idx <= '0;
      else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  // Next-state: one drain cycle lets the in-flight beat land, then NBINS clear cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clear_req) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_idx == {BIN_BITS{1'b1}}) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage 1: capture per-lane bin index and counted flag ----
  // Register lane bins; a lane counts only when the beat is accepted and kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      for (int k = 0; k < LANES; k++) bin_p1[k] <= '0;
    end else begin
      vld_p1 <= bus.stream_keep & {LANES{accept}};
      for (int k = 0; k < LANES; k++)
        bin_p1[k] <= bus.stream_data[k*WORD_WIDTH + WORD_WIDTH - 1 -: BIN_BITS];
    end
  end

  // ---- stage 2: per-bin lane tally and saturating counter update ----
  // Count stage-1 lanes hitting each bin and form the clipped next values.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      n_bin[b] = '0;
      for (int k = 0; k < LANES; k++)
        if (vld_p1[k] && (bin_p1[k] == BIN_BITS'(b)))
          n_bin[b] = n_bin[b] + (LOG2_LANES+1)'(1);
      {bin_sat[b], cnt_nxt[b]} = sat_add(cnt[b], n_bin[b]);
    end
    n_total = '0;
    for (int k = 0; k < LANES; k++)
      n_total = n_total + {{LOG2_LANES{1'b0}}, vld_p1[k]};
    {total_sat, total_nxt} = sat_add(total_q, n_total);
  end

  // Bin counters: the clear engine zeroes the indexed bin, otherwise accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBINS; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBINS; b++) begin
        if ((state == ST_CLEAR) && (clr_idx == BIN_BITS'(b))) cnt[b] <= '0;
        else                                                  cnt[b] <= cnt_nxt[b];
      end
    end
  end

  // Total and sticky overflow; both drop on the first clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else if ((state == ST_CLEAR) && (clr_idx == '0)) begin
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      total_q <= total_nxt;
      ovf_q   <= ovf_q | total_sat | (|bin_sat);
    end
  end

  // Query port: sample the addressed bin before this edge's update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      res_vld_q <= bus.query_valid;
      if (bus.query_valid) res_cnt_q <= cnt[bus.query_bin];
    end
  end
endmodule

// File: tb/tb_streaming_histogram_binned.sv
// Bench for streaming_histogram_binned: directed bin-mapping, keep, visibility,
// saturation, clear and reset scenarios plus a randomized run, checked by a
// query scoreboard against a cycle-stamped reference model.
module tb_streaming_histogram_binned;
  localparam int LANES = 4;
  localparam int WW    = 12;
  localparam int BB    = 6;
  localparam int NBINS = 64;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  streaming_histogram_binned_if #(.LOG2_LANES(2), .WORD_WIDTH(WW), .BIN_BITS(BB), .COUNT_WIDTH(32)) hif();
  streaming_histogram_binned_if #(.LOG2_LANES(2), .WORD_WIDTH(WW), .BIN_BITS(BB), .COUNT_WIDTH(4))  sif();

  streaming_histogram_binned #(.LOG2_LANES(2), .WORD_WIDTH(WW), .BIN_BITS(BB), .COUNT_WIDTH(32))
    dut (.clk(clk), .rst_n(rst_n), .bus(hif));
  streaming_histogram_binned #(.LOG2_LANES(2), .WORD_WIDTH(WW), .BIN_BITS(BB), .COUNT_WIDTH(4))
    dut_small (.clk(clk), .rst_n(rst_n), .bus(sif));

  typedef struct {
    int          cyc;
    logic [47:0] data;
    logic [3:0]  keep;
  } beat_t;

  longint unsigned m_cnt [NBINS];
  longint unsigned m_total;
  bit              m_ovf;
  beat_t           pend [$];
  longint unsigned sb [$];
  int              clr_c = -1;
  int              cyc = 0;
  int              n_tests = 0;
  int              n_fail = 0;

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < NBINS; b++) m_cnt[b] = 0;
    m_total = 0;
    m_ovf   = 0;
    pend.delete();
    clr_c   = -1;
  endfunction

  // Beats become visible two cycles after acceptance; a clear wipes everything
  // once its last bin has been zeroed.
  function automatic void model_advance(int t);
    beat_t bt;
    longint unsigned dd, w;
    int bin;
    while (pend.size() > 0 && pend[0].cyc <= t - 2) begin
      bt = pend.pop_front();
      dd = longint'(bt.data);
      for (int k = 0; k < LANES; k++) begin
        if (bt.keep[k]) begin
          w   = (dd >> (k * WW)) & 64'hFFF;
          bin = int'(w / 64);
          if (m_cnt[bin] == CMAX) m_ovf = 1; else m_cnt[bin]++;
          if (m_total == CMAX)    m_ovf = 1; else m_total++;
        end
      end
    end
    if (clr_c >= 0 && t >= clr_c + 2 + NBINS) begin
      for (int b = 0; b < NBINS; b++) m_cnt[b] = 0;
      m_total = 0;
      m_ovf   = 0;
      clr_c   = -1;
    end
  endfunction

  function automatic bit in_busy(int t);
    return (clr_c >= 0) && (t >= clr_c + 1) && (t <= clr_c + 1 + NBINS);
  endfunction

  function automatic longint unsigned exp_bin(int b, int t);
    if (clr_c >= 0 && t >= clr_c + 3 + b) return 0;
    return m_cnt[b];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle of main-DUT stimulus; checks status outputs of the current cycle,
  // records model effects, then advances the clock.
  task automatic drive(bit v, logic [47:0] d, logic [3:0] kp, bit clr, bit qv, int qb);
    logic [BB-1:0] qbv;
    qbv = qb[BB-1:0];
    model_advance(cyc);
    if (rst_n) begin
      check("stream_ready", hif.stream_ready, !in_busy(cyc));
      check("clear_busy", hif.clear_busy, in_busy(cyc));
      if (clr_c < 0) begin
        check("total_count", hif.total_count, m_total);
        check("overflow", hif.overflow, m_ovf);
      end
    end
    hif.stream_valid = v;
    hif.stream_data  = d;
    hif.stream_keep  = kp;
    hif.clear_req    = clr;
    hif.query_valid  = qv;
    hif.query_bin    = qbv;
    if (rst_n && v && !in_busy(cyc)) begin
      beat_t nb;
      nb.cyc = cyc; nb.data = d; nb.keep = kp;
      pend.push_back(nb);
    end
    if (qv) sb.push_back(exp_bin(qb, cyc));
    if (rst_n && clr && clr_c < 0) clr_c = cyc;
    tick();
    if (rst_n) check("result_valid_latency", hif.result_valid, qv);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, 0);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_ready"}, hif.stream_ready, 1);
    check({tag, "_busy"}, hif.clear_busy, 0);
    check({tag, "_result_valid"}, hif.result_valid, 0);
    check({tag, "_result_count"}, hif.result_count, 0);
    check({tag, "_total"}, hif.total_count, 0);
    check({tag, "_overflow"}, hif.overflow, 0);
  endtask

  task automatic do_reset();
    idle(2);
    rst_n = 1'b0;
    sif.stream_valid = 0; sif.query_valid = 0; sif.clear_req = 0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    check_reset_state("reset");
  endtask

  // Scoreboard monitor: every presented result must match the oldest query.
  always @(negedge clk) begin
    longint unsigned e;
    if (rst_n && hif.result_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result_unexpected at cycle %0d: got count %0d, expected no result", cyc, hif.result_count);
      end else begin
        e = sb.pop_front();
        check("result_count", hif.result_count, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] rand_word();
    int b;
    b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
    return WW'(b * 64 + int'($urandom_range(0, 63)));
  endfunction

  initial begin
    logic [47:0] beat_a, beat_ff, beat_pop, beat_held, rd;
    int n, c0;
    hif.stream_valid = 0; hif.stream_data = '0; hif.stream_keep = '0;
    hif.clear_req = 0; hif.query_valid = 0; hif.query_bin = '0;
    sif.stream_valid = 0; sif.stream_data = '0; sif.stream_keep = '0;
    sif.clear_req = 0; sif.query_valid = 0; sif.query_bin = '0;
    model_reset();

    beat_a    = {12'h040, 12'h0FF, 12'h0C0, 12'h0C5};
    beat_ff   = {4{12'hFFF}};
    beat_pop  = {12'hFC0, 12'h0C0, 12'h010, 12'h000};
    beat_held = {4{12'h800}};

    // Basic bin mapping
    do_reset();
    drive(1, beat_a, 4'b1111, 0, 0, 0);
    idle(1);
    drive(0, '0, '0, 0, 1, 3);
    drive(0, '0, '0, 0, 1, 1);
    drive(0, '0, '0, 0, 1, 0);
    idle(2);

    // Keep mask
    do_reset();
    drive(1, beat_a, 4'b0101, 0, 0, 0);
    idle(1);
    drive(0, '0, '0, 0, 1, 3);
    drive(0, '0, '0, 0, 1, 1);
    idle(2);

    // Visibility: query in N, N+1, N+2
    do_reset();
    drive(1, beat_ff, 4'b1111, 0, 1, 63);
    drive(0, '0, '0, 0, 1, 63);
    drive(0, '0, '0, 0, 1, 63);
    idle(2);

    // Saturation on the narrow-counter instance
    do_reset();
    sif.stream_valid = 1; sif.stream_data = beat_ff; sif.stream_keep = 4'hF;
    idle(4);
    sif.stream_valid = 0;
    check("sat_overflow_before", sif.overflow, 0);
    check("sat_total_before", sif.total_count, 12);
    idle(1);
    check("sat_overflow_after", sif.overflow, 1);
    check("sat_total_after", sif.total_count, 15);
    sif.query_valid = 1; sif.query_bin = 6'd63;
    idle(1);
    sif.query_valid = 0;
    check("sat_result_valid", sif.result_valid, 1);
    check("sat_bin63", sif.result_count, 15);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rd = {rand_word(), rand_word(), rand_word(), rand_word()};
      n  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      drive($urandom_range(0, 9) < 7, rd, 4'($urandom_range(0, 15)), 0,
            $urandom_range(0, 1) == 1, n);
    end
    idle(3);

    // Clear sequence with coincident beat, held beat, mid-clear queries, second request
    do_reset();
    drive(1, beat_pop, 4'b1111, 0, 0, 0);
    drive(1, beat_pop, 4'b1111, 0, 0, 0);
    idle(2);
    c0 = cyc;
    drive(1, beat_a, 4'b1111, 1, 0, 0);
    for (int i = 1; i <= NBINS + 1; i++) begin
      case (i)
        5:       drive(1, beat_held, 4'b1111, 0, 1, 3);
        6:       drive(1, beat_held, 4'b1111, 0, 1, 3);
        7:       drive(1, beat_held, 4'b1111, 0, 1, 0);
        8:       drive(1, beat_held, 4'b1111, 0, 1, 63);
        10:      drive(1, beat_held, 4'b1111, 1, 0, 0);
        default: drive(1, beat_held, 4'b1111, 0, 0, 0);
      endcase
    end
    check("clear_duration", cyc - c0, NBINS + 2);
    for (int b = 0; b < NBINS; b++) drive(0, '0, '0, 0, 1, b);
    idle(2);

    // Async reset in the middle of a clear
    drive(1, beat_pop, 4'b1111, 0, 0, 0);
    idle(2);
    c0 = cyc;
    drive(0, '0, '0, 1, 0, 0);
    while (cyc < c0 + 2 + 20 - 1) drive(0, '0, '0, 0, 0, 0);
    drive(0, '0, '0, 0, 1, 63);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midclear_busy", hif.clear_busy, 0);
    check("midclear_result_valid", hif.result_valid, 0);
    check("midclear_result_count", hif.result_count, 0);
    check("midclear_total", hif.total_count, 0);
    check("midclear_overflow", hif.overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    check_reset_state("post_reset");
    drive(1, beat_a, 4'b1111, 0, 1, 0);
    drive(0, '0, '0, 0, 1, 63);
    drive(0, '0, '0, 0, 1, 3);
    drive(0, '0, '0, 0, 1, 1);
    idle(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
